// File: rtl/ima_adpcm_blk_ctrl.sv
// Block sequencer for the IMA ADPCM encoder: paces samples in, packs four 4-bit codes
// per word and frames them into blocks led by a predictor/step-index header.
module ima_adpcm_blk_ctrl #(
    parameter int NIBBLES_PER_BLOCK = 504
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] sampIn,
    input  logic        sampValid,
    output logic        sampReady,
    output logic [15:0] encSamp,
    output logic        encValid,
    input  logic        encReady,
    input  logic [3:0]  encPcm,
    input  logic        encPcmValid,
    input  logic [15:0] encPredSamp,
    input  logic [6:0]  encStepIdx,
    output logic [15:0] wordOut,
    output logic        wordValid,
    input  logic        wordReady,
    output logic        wordFirst,
    output logic        wordLast,
    output logic        blockDone
);

    typedef enum logic [2:0] {
        ST_HDR_CAP = 3'd0,
        ST_HDR0    = 3'd1,
        ST_HDR1    = 3'd2,
        ST_FEED    = 3'd3,
        ST_WAIT    = 3'd4,
        ST_EMIT    = 3'd5
    } state_t;

    localparam logic [11:0] LAST_CNT = 12'(NIBBLES_PER_BLOCK);

    state_t      state_r, state_s;
    logic [11:0] cnt_r, cnt_s;
    logic [15:0] pack_r, pack_s;
    logic [15:0] hdr1_r, hdr1_s;
    logic [15:0] word_out_r, word_out_s;
    logic        word_valid_r, word_valid_s;
    logic        word_first_r, word_first_s;
    logic        word_last_r, word_last_s;
    logic        block_done_r, block_done_s;
    logic        samp_ready_s, enc_valid_s;
    logic [15:0] enc_samp_s;

    // Next-state, next register values and the combinational sample handshake.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        pack_s       = pack_r;
        hdr1_s       = hdr1_r;
        word_out_s   = word_out_r;
        word_valid_s = word_valid_r;
        word_first_s = word_first_r;
        word_last_s  = word_last_r;
        block_done_s = 1'b0;
        samp_ready_s = 1'b0;
        enc_valid_s  = 1'b0;
        enc_samp_s   = 16'd0;

        case (state_r)
            ST_HDR_CAP: begin
                // H0 goes straight into the output register; only H1 needs holding.
                if (enable && encReady) begin
                    hdr1_s       = {9'd0, encStepIdx};
                    word_out_s   = encPredSamp;
                    word_valid_s = 1'b1;
                    word_first_s = 1'b1;
                    state_s      = ST_HDR0;
                end else begin
                    state_s = ST_HDR_CAP;
                end
            end
            ST_HDR0: begin
                if (wordReady) begin
                    word_out_s   = hdr1_r;
                    word_first_s = 1'b0;
                    state_s      = ST_HDR1;
                end else begin
                    state_s = ST_HDR0;
                end
            end
            ST_HDR1: begin
                if (wordReady) begin
                    word_valid_s = 1'b0;
                    cnt_s        = 12'd0;
                    pack_s       = 16'd0;
                    state_s      = ST_FEED;
                end else begin
                    state_s = ST_HDR1;
                end
            end
            ST_FEED: begin
                samp_ready_s = encReady;
                enc_valid_s  = sampValid & encReady;
                enc_samp_s   = sampIn;
                if (enc_valid_s) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_FEED;
                end
            end
            ST_WAIT: begin
                if (encPcmValid) begin
                    pack_s[{cnt_r[1:0], 2'b00} +: 4] = encPcm;
                    cnt_s = cnt_r + 12'd1;
                    // Fourth code of the word: present it on the next cycle.
                    if (cnt_r[1:0] == 2'd3) begin
                        word_out_s   = pack_s;
                        word_valid_s = 1'b1;
                        word_last_s  = (cnt_s == LAST_CNT);
                        state_s      = ST_EMIT;
                    end else begin
                        state_s = ST_FEED;
                    end
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_EMIT: begin
                if (wordReady) begin
                    word_valid_s = 1'b0;
                    word_last_s  = 1'b0;
                    block_done_s = word_last_r;
                    if (word_last_r) begin
                        state_s = ST_HDR_CAP;
                    end else begin
                        state_s = ST_FEED;
                    end
                end else begin
                    state_s = ST_EMIT;
                end
            end
            default: begin
                state_s      = ST_HDR_CAP;
                word_valid_s = 1'b0;
                word_first_s = 1'b0;
                word_last_s  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_HDR_CAP;
            cnt_r        <= 12'd0;
            pack_r       <= 16'd0;
            hdr1_r       <= 16'd0;
            word_out_r   <= 16'd0;
            word_valid_r <= 1'b0;
            word_first_r <= 1'b0;
            word_last_r  <= 1'b0;
            block_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            pack_r       <= pack_s;
            hdr1_r       <= hdr1_s;
            word_out_r   <= word_out_s;
            word_valid_r <= word_valid_s;
            word_first_r <= word_first_s;
            word_last_r  <= word_last_s;
            block_done_r <= block_done_s;
        end
    end

    assign sampReady = samp_ready_s;
    assign encValid  = enc_valid_s;
    assign encSamp   = enc_samp_s;
    assign wordOut   = word_out_r;
    assign wordValid = word_valid_r;
    assign wordFirst = word_first_r;
    assign wordLast  = word_last_r;
    assign blockDone = block_done_r;

endmodule

// File: doc/ima_adpcm_blk_ctrl.md
# ima_adpcm_blk_ctrl

Block sequencer for the IMA ADPCM encoder. It sits between a 16-bit PCM sample source and the `ima_adpcm_enc` instance, and handles three jobs:
- paces samples into the encoder one at a time;
- collects the 4-bit codes and packs four codes per 16-bit word;
- frames the result into fixed-size blocks, each led by a two-word header holding the encoder's predictor and step index at block start.

The output word stream feeds the storage/transport FIFO.

## Interface
- `NIBBLES_PER_BLOCK`, default 504: encoded samples per block. Must be a multiple of 4, range 4..4092.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `enable`  in  1  permits starting a new block. Sampled only in HDR_CAP.
- `sampIn`  in  16  signed PCM sample.
- `sampValid`  in  1  source sample valid.
- `sampReady`  out  1  sample accepted when `sampValid` and `sampReady` are both high.
- `encSamp`  out  16  to encoder `inSamp`.
- `encValid`  out  1  to encoder `inValid`.
- `encReady`  in  1  from encoder `inReady`.
- `encPcm`  in  4  from encoder `outPCM`.
- `encPcmValid`  in  1  from encoder `outValid`.
- `encPredSamp`  in  16  from encoder `outPredictSamp`.
- `encStepIdx`  in  7  from encoder `outStepIndex`.
- `wordOut`  out  16  packed output word.
- `wordValid`  out  1  output word valid.
- `wordReady`  in  1  downstream accept.
- `wordFirst`  out  1  high with header word 0.
- `wordLast`  out  1  high with the final data word of the block.
- `blockDone`  out  1  one-cycle pulse after the last word of a block is accepted.

## Operation
- **Block format:** H0, H1, then `NIBBLES_PER_BLOCK/4` data words.
  - H0 = `encPredSamp`.
  - H1 = {9'b0, `encStepIdx`}.
  - Data word: nibble k (k = 0..3, in encode order) occupies bits [4k+3:4k].
- **HDR_CAP:** wait for `enable`=1 and `encReady`=1 (encoder idle, so its state is stable).
  - Register H0 and H1 into header registers.
  - Load `wordOut`=H0, `wordValid`=1, `wordFirst`=1.
  - Go to HDR0.
- **HDR0:** hold outputs until `wordReady`.
  - On accept: `wordOut`=H1, `wordFirst`=0.
  - Go to HDR1.
- **HDR1:** hold until `wordReady`.
  - On accept: `wordValid`=0, clear nibble counter and pack register.
  - Go to FEED.
- **FEED:** combinational pass-through.
  - `sampReady` = `encReady`.
  - `encValid` = `sampValid` & `encReady`.
  - `encSamp` = `sampIn`.
  - On transfer, go to WAIT.
- **WAIT:** `sampReady`=0, `encValid`=0.
  - On `encPcmValid`: write `encPcm` into nibble slot `cnt[1:0]` and increment the 12-bit `cnt`.
  - If slot was 3, go to EMIT; otherwise go to FEED.
- **EMIT:** `wordOut`=pack register, `wordValid`=1, `wordLast` = (`cnt` == `NIBBLES_PER_BLOCK`).
  - On `wordReady`: deassert `wordValid` and `wordLast`.
  - If last: pulse `blockDone` and go to HDR_CAP. Otherwise go to FEED.
- **Outside FEED:** `sampReady`=0, `encValid`=0, `encSamp`=0.
- **Blocks are atomic:** `enable` low mid-block has no effect; the block completes and the controller then parks in HDR_CAP.
- **Stray codes:** `encPcmValid` outside WAIT is ignored. This covers stale codes after a controller reset while the encoder was busy.
- **Sample consumption:** exactly one sample is outstanding in the encoder at any time. No sample is consumed during header or EMIT states.

## Timing
- **Reset values:** state=HDR_CAP, `wordOut`=0, `wordValid`=0, `wordFirst`=0, `wordLast`=0, `blockDone`=0, `sampReady`=0, `encValid`=0, counters=0. Assertion is asynchronous; release is synchronous to the next edge.
- `wordOut`, `wordValid`, `wordFirst`, `wordLast`, `blockDone` are registered. `sampReady`, `encValid`, `encSamp` are combinational from state and inputs.
- **H0 latency:** H0 appears 1 cycle after the HDR_CAP conditions are met.
- **Per-sample cost:** 1 FEED cycle + encoder latency (6 cycles from `encValid` to `encPcmValid`) + 1 cycle to return to FEED. `encReady` is already 1 when `encPcmValid` is seen.
- **Data word:** EMIT asserts `wordValid` the cycle after the 4th `encPcmValid`.
- **Backpressure:** `wordValid` and data stay stable until accepted. `wordReady` high with no `wordValid` has no effect.
- **Header timing:** H0/H1 reflect encoder state after the previous block's last code. The predictor and step index are updated on the same edge as `encPcmValid`.

## Test plan
- **All-zero input:** `NIBBLES_PER_BLOCK`=8, encoder freshly reset, `sampIn`=0 continuous, `wordReady`=1 -> words 0x0000 (`wordFirst`), 0x0000, 0x0000, 0x0000 (`wordLast`), then `blockDone` pulse; repeats while `enable`=1.
- **First code from a step:** `NIBBLES_PER_BLOCK`=4, first sample 0x1000 then 0x0000 ×3 -> data word bits [3:0]=0x7. Next block H1 low bits equal the golden-model step index; first step is 0→8.
- **Disable mid-block:** deassert `enable` after 2 samples -> block completes with all 4 words; controller stays in HDR_CAP and `sampReady` stays 0 until `enable`=1.
- **Backpressure:** hold `wordReady`=0 for 5 cycles at H0, H1 and EMIT -> `wordOut` stable; `sampReady` stays 0 throughout; no sample lost or duplicated against the golden model.
- **Reset mid-block:** drive `reset`=0 during WAIT -> all outputs 0 immediately. After release (encoder also reset), the controller waits for `encReady`=1, ignores any stray `encPcmValid`, and the next block starts with H0=0x0000, H1=0x0000.
- **Sample starvation:** `sampValid` gaps of 0–3 random cycles over a 504-nibble block -> output word stream equals the golden-model block exactly.
